ens_vote_argmax: RTL and testbench



---
 rtl/ens_vote_argmax.sv | 136 +++++++++++++
 tb/tb_ens_vote_argmax.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ens_vote_argmax.sv
// Ensemble vote accumulator with sequential argmax over the class-wise sums.
// Optional second-best margin output is enabled by defining ENS_VOTE_MARGIN_EN.
module ens_vote_argmax #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 2,
    parameter int unsigned NUM_ENS     = 4,
    parameter int unsigned CLASS_W     = 4,
    localparam int unsigned ACC_W      = SCORE_W + $clog2(NUM_ENS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_CLASSES*SCORE_W-1:0] s_scores,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CLASS_W-1:0]             m_class,
`ifdef ENS_VOTE_MARGIN_EN
    output logic [ACC_W-1:0]               m_margin,
`endif
    output logic [ACC_W-1:0]               m_score
);

    localparam int unsigned CNT_W = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_CLASSES + 1);

    typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [ACC_W-1:0]   acc [NUM_CLASSES];
    logic [ACC_W-1:0]   best_sum;
    logic [CLASS_W-1:0] best_class;
    logic [ACC_W-1:0]   cur;
`ifdef ENS_VOTE_MARGIN_EN
    logic [ACC_W-1:0]   second;
`endif

    // Sum of the class currently under comparison
    always_comb begin
        cur = '0;
        for (int c = 0; c < int'(NUM_CLASSES); c++) begin
            if (idx == IDX_W'(c)) cur = acc[c];
        end
    end

    // Control, accumulation, scan and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            cnt        <= '0;
            idx        <= '0;
            for (int c = 0; c < int'(NUM_CLASSES); c++) acc[c] <= '0;
            best_sum   <= '0;
            best_class <= '0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_class    <= '0;
            m_score    <= '0;
`ifdef ENS_VOTE_MARGIN_EN
            second     <= '0;
            m_margin   <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    if (s_valid && s_ready) begin
                        for (int c = 0; c < int'(NUM_CLASSES); c++) begin
                            acc[c] <= acc[c] + ACC_W'(s_scores[c*SCORE_W +: SCORE_W]);
                        end
                        if (cnt == CNT_W'(NUM_ENS - 1)) begin
                            cnt     <= '0;
                            idx     <= '0;
                            s_ready <= 1'b0;
                            state   <= SCAN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                SCAN: begin
                    s_ready <= 1'b0;
                    // Wrap-up cycle after the last class publishes the winner
                    if (idx == IDX_W'(NUM_CLASSES)) begin
                        m_valid <= 1'b1;
                        m_class <= best_class;
                        m_score <= best_sum;
`ifdef ENS_VOTE_MARGIN_EN
                        m_margin <= best_sum - second;
`endif
                        idx     <= '0;
                        state   <= HOLD;
                    end else begin
                        // Strictly greater replaces best, so ties keep the lowest index
                        if (idx == '0 || cur > best_sum) begin
                            best_sum   <= cur;
                            best_class <= CLASS_W'(idx);
`ifdef ENS_VOTE_MARGIN_EN
                            second     <= (idx == '0) ? '0 : best_sum;
                        end else if (cur > second) begin
                            second     <= cur;
`endif
                        end
                        idx <= idx + IDX_W'(1);
                    end
                end

                HOLD: begin
                    s_ready <= 1'b0;
                    if (m_ready) begin
                        for (int c = 0; c < int'(NUM_CLASSES); c++) acc[c] <= '0;
                        best_sum   <= '0;
                        best_class <= '0;
`ifdef ENS_VOTE_MARGIN_EN
                        second     <= '0;
`endif
                        m_valid    <= 1'b0;
                        s_ready    <= 1'b1;
                        state      <= ACCUM;
                    end
                end

                default: begin
                    state   <= ACCUM;
                    s_ready <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Directed testbench for ens_vote_argmax (default parameters, optional margin checks).
`timescale 1ns/1ps
module tb_ens_vote_argmax;

    localparam int unsigned NC = 10;
    localparam int unsigned SW = 2;
    localparam int unsigned VW = NC * SW;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [VW-1:0] s_scores;
    logic          m_valid;
    logic          m_ready;
    logic [3:0]    m_class;
    logic [AW-1:0] m_score;
`ifdef ENS_VOTE_MARGIN_EN
    logic [AW-1:0] m_margin;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    ens_vote_argmax dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_scores (s_scores),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
`ifdef ENS_VOTE_MARGIN_EN
        .m_margin (m_margin),
`endif
        .m_score  (m_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] ln(input int c, input int v);
        logic [VW-1:0] r;
        r = '0;
        r[c*SW +: SW] = SW'(v);
        return r;
    endfunction

    task automatic send_vec(input logic [VW-1:0] v);
        int n;
        n = 0;
        s_valid  = 1'b1;
        s_scores = v;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) check("send_timeout", 0, 1);
        step();
        acc_cyc = cyc;
        s_valid = 1'b0;
    endtask

    task automatic send4(input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [VW-1:0] c, input logic [VW-1:0] d);
        send_vec(a);
        send_vec(b);
        send_vec(c);
        send_vec(d);
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 40) begin
            step();
            n++;
        end
        if (!m_valid) check({tag, "_timeout"}, 0, 1);
        else check({tag, "_latency"}, 32'(cyc - acc_cyc), 11);
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_scores = '0;
        m_ready  = 1'b1;
        step();
        step();
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_class", 32'(m_class), 0);
        check("rst_m_score", 32'(m_score), 0);
        rst = 1'b0;
        step();
        check("post_rst_s_ready", 32'(s_ready), 1);

        // Single strong class, latency and one-cycle m_valid
        send4(ln(3, 3), ln(3, 3), ln(3, 3), ln(3, 3));
        check("t1_scan_s_ready", 32'(s_ready), 0);
        wait_result("t1");
        check("t1_class", 32'(m_class), 3);
        check("t1_score", 32'(m_score), 12);
        step();
        check("t1_valid_drop", 32'(m_valid), 0);
        check("t1_s_ready_back", 32'(s_ready), 1);

        // Tie between class 2 and class 7 goes to the lower index
        send4(ln(2, 2) | ln(7, 2) | ln(0, 1), ln(2, 2) | ln(7, 2) | ln(0, 1),
              ln(2, 2) | ln(7, 2) | ln(0, 1), ln(2, 2) | ln(7, 2) | ln(0, 1));
        wait_result("t2");
        check("t2_class", 32'(m_class), 2);
        check("t2_score", 32'(m_score), 8);
        step();

        // All-zero votes
        send4('0, '0, '0, '0);
        wait_result("t3");
        check("t3_class", 32'(m_class), 0);
        check("t3_score", 32'(m_score), 0);
        step();

        // Backpressure on the result while upstream keeps offering data
        m_ready = 1'b0;
        send4(ln(6, 3) | ln(1, 1), ln(6, 3) | ln(1, 1), ln(6, 3) | ln(1, 1), ln(6, 3) | ln(1, 1));
        wait_result("t4");
        s_valid  = 1'b1;
        s_scores = ln(0, 3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_valid", 32'(m_valid), 1);
            check("t4_hold_s_ready", 32'(s_ready), 0);
            check("t4_hold_class", 32'(m_class), 6);
            check("t4_hold_score", 32'(m_score), 12);
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        step();
        m_ready = 1'b0;
        check("t4_release_valid", 32'(m_valid), 0);
        check("t4_payload_kept", 32'(m_class), 6);
        m_ready = 1'b1;
        send4(ln(8, 1), ln(8, 1), ln(8, 1), ln(8, 1));
        wait_result("t4b");
        check("t4b_class", 32'(m_class), 8);
        check("t4b_score", 32'(m_score), 4);
        step();

        // Reset in the middle of accumulation discards partial sums
        send_vec(ln(5, 3));
        send_vec(ln(5, 3));
        rst = 1'b1;
        #1;
        check("t5_rst_m_valid", 32'(m_valid), 0);
        check("t5_rst_s_ready", 32'(s_ready), 0);
        check("t5_rst_m_class", 32'(m_class), 0);
        step();
        rst = 1'b0;
        step();
        send4(ln(1, 2), ln(1, 2), ln(1, 2), ln(1, 2));
        wait_result("t5");
        check("t5_class", 32'(m_class), 1);
        check("t5_score", 32'(m_score), 8);
        step();

`ifdef ENS_VOTE_MARGIN_EN
        // Margin against the runner-up
        send4(ln(4, 3) | ln(9, 3), ln(4, 3) | ln(9, 3), ln(4, 3) | ln(9, 3), ln(4, 3));
        wait_result("m1");
        check("m1_class", 32'(m_class), 4);
        check("m1_score", 32'(m_score), 12);
        check("m1_margin", 32'(m_margin), 3);
        step();

        // Tied leaders give zero margin
        send4(ln(0, 2) | ln(6, 2), ln(0, 2) | ln(6, 2), ln(0, 2) | ln(6, 2), ln(0, 1) | ln(6, 1));
        wait_result("m2");
        check("m2_class", 32'(m_class), 0);
        check("m2_score", 32'(m_score), 7);
        check("m2_margin", 32'(m_margin), 0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
